line_clear_engine: RTL and testbench
====================================

# line_clear_engine

Sequential row-clear stage that consumes the merged board produced by the piece-overlay stage when a piece locks. It scans the 10x20 board bottom-to-top, removes every completely filled row, and collapses the rows above it downward. It then returns the compacted board and the number of rows removed, to be written back as the new locked board.

## Interface
- Parameters: none. Board dimensions are fixed by `game_state_pkg::game_state_t`: `screen[x][y]`, x = 0..9 columns, y = 0..19 rows, y = 0 top, y = 19 bottom.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to process `board_in`. Sampled only when `busy` = 0.
- `board_in` in `game_state_pkg::game_state_t`: board to compact (locked board with the active piece blitted in). Sampled only on the accepted `start` edge.
- `busy` out 1: high while a request is in progress.
- `done` out 1: single-cycle pulse when `board_out`/`lines_cleared` are updated.
- `board_out` out `game_state_pkg::game_state_t`: compacted board. Holds its value between requests.
- `lines_cleared` out 5: rows removed by the last request (0..20). Holds its value between requests.

## Operation
- States: IDLE, CHECK, SHIFT, DONE. `busy` = (state != IDLE).
- IDLE:
  - On `start`=1, register `board_in` into working board `work`, set row pointer r=19 and count=0, then go to CHECK.
  - `start`=0 stays in IDLE.
- CHECK: row r is full iff `work.screen[x][r]`=1 for all x in 0..9.
  - Full: go to SHIFT.
  - Not full, r=0: go to DONE.
  - Not full, r>0: r <= r-1, stay in CHECK.
- SHIFT, one cycle. For every column x:
  - `work.screen[x][y]` <= `work.screen[x][y-1]` for 1<=y<=r.
  - `work.screen[x][0]` <= 0.
  - Rows below r are unchanged.
  - count <= count+1. r is unchanged, so the row that fell into r is re-checked. Go to CHECK.
- DONE, one cycle:
  - `done`=1.
  - `board_out` = `work`, `lines_cleared` = count. Both are registered on the CHECK->DONE transition and are visible in the DONE cycle.
  - Go to IDLE.
- `start` while `busy`=1 is ignored and has no queued effect.
- `board_in` changes after acceptance do not affect the request in progress.
- count width: 5 bits. The maximum is 20 (all rows full), so count never wraps.
- The block does not check row validity or game-over conditions. Any bit pattern is legal input.

## Timing
- Reset (synchronous, highest priority, any state including mid-scan):
  - state=IDLE, `busy`=0, `done`=0.
  - `board_out` = all zeros, `lines_cleared` = 0, r=19, count=0.
  - An in-flight request is dropped with no `done`.
- Let cycle 0 be the cycle in which `start`=1 is sampled with `busy`=0, and let k = number of rows cleared.
  - Cycles 1..20+2k: CHECK/SHIFT (20 + k CHECK cycles, k SHIFT cycles), `busy`=1.
  - Cycle 21+2k: DONE, `done`=1, `busy`=1, outputs valid.
  - Cycle 22+2k: IDLE, `busy`=0. A new `start` may be sampled in this cycle.
- Latency summary: k=0 gives `done` at cycle 21; k=4 gives cycle 29; k=20 gives cycle 61.
- `start` held high continuously produces back-to-back requests, one accepted per IDLE cycle.
- `board_out`/`lines_cleared` change only in the DONE cycle. They are stable at all other times.

## Test plan
- Reset then empty board, pulse `start`:
  - `done` exactly at cycle 21.
  - `lines_cleared`=0, `board_out` all zeros, `busy` high cycles 1..21.
- Board with row 19 full plus a single cell at (3,18):
  - `lines_cleared`=1, `done` at cycle 23.
  - `board_out` has only (3,19) set.
- Rows 16..19 full plus cell (0,15), and also row 10 full:
  - `lines_cleared`=5, `done` at cycle 31.
  - `board_out` has only (0,19) set.
- All 200 cells set:
  - `lines_cleared`=20, `done` at cycle 61, `board_out` all zeros.
  - Separately, row 0 full only: `lines_cleared`=1, `board_out` all zeros.
- Non-full rows interleaved, with rows 19 and 17 full and row 18 = column 5 only:
  - `board_out` row 19 = column 5 only, other rows zero.
  - `lines_cleared`=2.
- Protocol checks:
  - Pulse `start` again at cycle 5 with a different board: ignored, and the result matches the first board.
  - Assert `reset` at cycle 10 of a request: no `done`, outputs return to zero, and the next `start` processes normally.

Source files
------------

// File: rtl/line_clear_engine.sv
// Row-clear stage: scans the locked board bottom-up, drops full rows,
// collapses the rows above them and reports the compacted board.
package game_state_pkg;
  typedef struct packed {
    logic [9:0][19:0] screen;
  } game_state_t;
endpackage

module line_clear_engine
  import game_state_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  game_state_t board_in,
  output logic        busy,
  output logic        done,
  output game_state_t board_out,
  output logic [4:0]  lines_cleared
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  game_state_t work;
  game_state_t shifted;
  logic [4:0]  r;
  logic [4:0]  count;
  logic        full;

  assign busy = (state != IDLE);

  always_comb begin
    full = 1'b1;
    for (int x = 0; x < 10; x++) begin
      full = full & work.screen[x][r];
    end
  end

  // Rows 0..r fall by one; rows below r keep their contents.
  always_comb begin
    shifted = work;
    for (int x = 0; x < 10; x++) begin
      for (int y = 1; y < 20; y++) begin
        if (y <= int'(r)) begin
          shifted.screen[x][y] = work.screen[x][y-1];
        end
      end
      shifted.screen[x][0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      done          <= 1'b0;
      board_out     <= '0;
      lines_cleared <= '0;
      work          <= '0;
      r             <= 5'd19;
      count         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            work  <= board_in;
            r     <= 5'd19;
            count <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (full) begin
            state <= SHIFT;
          end else if (r == 5'd0) begin
            board_out     <= work;
            lines_cleared <= count;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            r <= r - 5'd1;
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count + 5'd1;
          state <= CHECK;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: latency, compaction result
// and start/reset protocol against hand-computed boards.
module tb_line_clear_engine;
  import game_state_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  game_state_t board_in;
  logic        busy;
  logic        done;
  game_state_t board_out;
  logic [4:0]  lines_cleared;

  int n_vec;
  int n_err;

  line_clear_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [199:0] got,
    input logic [199:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic game_state_t set_cell(
    input game_state_t b,
    input int x,
    input int y
  );
    b.screen[x][y] = 1'b1;
    return b;
  endfunction

  function automatic game_state_t set_row(
    input game_state_t b,
    input int y
  );
    for (int x = 0; x < 10; x++) b.screen[x][y] = 1'b1;
    return b;
  endfunction

  // inject=1 pulses start with an all-ones board at cycle 5.
  task automatic run_req(
    input string       tag,
    input game_state_t b,
    input game_state_t exp_b,
    input int          exp_k,
    input int          exp_cyc,
    input bit          inject
  );
    int  cyc;
    bit  busy_ok;
    game_state_t ones;
    ones    = '1;
    busy_ok = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    board_in = b;
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc <= 80) begin
      if (cyc > 1) @(negedge clk);
      start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
      if (inject && cyc == 5) begin
        start    = 1'b1;
        board_in = ones;
      end
      cyc++;
    end
    board_in = ones;
    chk({tag, "_done_cyc"}, 200'(cyc), 200'(exp_cyc));
    chk({tag, "_busy"}, 200'(busy_ok), 200'(1));
    chk({tag, "_lines"}, 200'(lines_cleared), 200'(exp_k));
    chk({tag, "_board"}, board_out, exp_b);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 200'(0));
    chk({tag, "_hold"}, board_out, exp_b);
  endtask

  game_state_t b3, e3, b4, e4, b7, e7, zero, ones;
  int seen_done;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    board_in = '0;
    zero     = '0;
    ones     = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_board", board_out, zero);
    chk("rst_lines", 200'(lines_cleared), 200'(0));

    run_req("empty", zero, zero, 0, 21, 1'b0);

    b3 = set_cell(set_row(zero, 19), 3, 18);
    e3 = set_cell(zero, 3, 19);
    run_req("one", b3, e3, 1, 23, 1'b0);

    b4 = zero;
    for (int y = 16; y < 20; y++) b4 = set_row(b4, y);
    b4 = set_row(set_cell(b4, 0, 15), 10);
    e4 = set_cell(zero, 0, 19);
    run_req("five", b4, e4, 5, 31, 1'b0);

    run_req("all", ones, zero, 20, 61, 1'b0);
    run_req("top", set_row(zero, 0), zero, 1, 23, 1'b0);

    b7 = set_cell(set_row(set_row(zero, 19), 17), 5, 18);
    e7 = set_cell(zero, 5, 19);
    run_req("inter", b7, e7, 2, 25, 1'b0);

    run_req("ign", b3, e3, 1, 23, 1'b1);

    // Reset mid-request: expect no done and cleared outputs.
    seen_done = 0;
    @(negedge clk);
    start    = 1'b1;
    board_in = b4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 200'(busy), 200'(0));
    chk("mid_rst_board", board_out, zero);
    chk("mid_rst_lines", 200'(lines_cleared), 200'(0));
    for (int c = 0; c < 60; c++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("mid_rst_nodone", 200'(seen_done), 200'(0));

    run_req("after", b7, e7, 2, 25, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
